// File: rtl/ifns_serial_encoder.sv
// Serial greedy encoder: datain becomes CODE_W Fibonacci-weighted digits, DPC digits per cycle.
// Handshaked in/out with an IDLE/CONV/DONE controller; out-of-range words flag code_err.
module ifns_serial_encoder #(
  parameter int DATA_W = 18,
  parameter int CODE_W = 26,
  parameter int DPC    = 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] datain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] codeout,
  output logic              code_err,
  output logic              busy
);

  function automatic logic [63:0] fib(input int n);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    a = 64'd1;
    b = 64'd1;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    if (n <= 1) return a;
    else return b;
  endfunction

  localparam logic [63:0] FIB_LIMIT  = fib(CODE_W + 2);
  localparam logic [63:0] FIB_TOP_HI = fib(CODE_W + 1);
  localparam logic [63:0] FIB_TOP_LO = fib(CODE_W);
  localparam int RES_W = $clog2(FIB_LIMIT);
  localparam int IDX_W = $clog2(CODE_W + 1);
  localparam logic [IDX_W-1:0] IDX_START = IDX_W'(CODE_W);
  localparam logic [IDX_W-1:0] IDX_STEP  = IDX_W'(DPC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_r;
  logic [RES_W-1:0]  res_r;
  logic [RES_W-1:0]  fhi_r;
  logic [RES_W-1:0]  flo_r;
  logic [CODE_W-1:0] dig_r;
  logic [IDX_W-1:0]  idx_r;
  logic              err_r;

  logic              accept_s;
  logic [63:0]       din_wide_s;
  logic              cap_err_s;
  logic [RES_W-1:0]  cap_res_s;
  logic [RES_W-1:0]  res_nxt_s;
  logic [RES_W-1:0]  fhi_nxt_s;
  logic [RES_W-1:0]  flo_nxt_s;
  logic [RES_W-1:0]  fsub_s;
  logic [CODE_W-1:0] dig_nxt_s;

  // Handshake decode and range check of the incoming word.
  always_comb begin
    case (state_r)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    out_valid  = (state_r == ST_DONE);
    busy       = (state_r == ST_CONV);
    accept_s   = in_valid && in_ready;
    din_wide_s = 64'(datain);
    cap_err_s  = (din_wide_s >= FIB_LIMIT);
    if (cap_err_s) cap_res_s = '0;
    else cap_res_s = din_wide_s[RES_W-1:0];
  end

  // Resolve DPC digits; the weight pair (Fib(k+1), Fib(k)) walks down by subtraction.
  always_comb begin
    res_nxt_s = res_r;
    fhi_nxt_s = fhi_r;
    flo_nxt_s = flo_r;
    dig_nxt_s = dig_r;
    fsub_s    = '0;
    for (int j = 0; j < DPC; j++) begin
      if (res_nxt_s >= fhi_nxt_s) begin
        res_nxt_s = res_nxt_s - flo_nxt_s;
        dig_nxt_s = {dig_nxt_s[CODE_W-2:0], 1'b1};
      end else begin
        dig_nxt_s = {dig_nxt_s[CODE_W-2:0], 1'b0};
      end
      fsub_s    = fhi_nxt_s - flo_nxt_s;
      fhi_nxt_s = flo_nxt_s;
      flo_nxt_s = fsub_s;
    end
  end

  // Controller and datapath registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      res_r    <= '0;
      fhi_r    <= '0;
      flo_r    <= '0;
      dig_r    <= '0;
      idx_r    <= '0;
      err_r    <= 1'b0;
      codeout  <= '0;
      code_err <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            state_r <= ST_CONV;
            res_r   <= cap_res_s;
            err_r   <= cap_err_s;
            fhi_r   <= FIB_TOP_HI[RES_W-1:0];
            flo_r   <= FIB_TOP_LO[RES_W-1:0];
            dig_r   <= '0;
            idx_r   <= IDX_START;
          end else if (state_r == ST_DONE && out_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        ST_CONV: begin
          res_r <= res_nxt_s;
          fhi_r <= fhi_nxt_s;
          flo_r <= flo_nxt_s;
          dig_r <= dig_nxt_s;
          idx_r <= idx_r - IDX_STEP;
          if (idx_r == IDX_STEP) begin
            state_r  <= ST_DONE;
            codeout  <= err_r ? '0 : dig_nxt_s;
            code_err <= err_r;
          end else begin
            state_r <= ST_CONV;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifns_serial_encoder.sv
// Self-checking bench: three encoder configurations against a greedy Fibonacci reference model.
module tb_ifns_serial_encoder;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // default configuration (CODE_W=26, DPC=1)
  logic a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_code_err, a_busy;
  logic [17:0] a_datain = '0;
  logic [25:0] a_codeout;
  // DPC=2
  logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_code_err, b_busy;
  logic [17:0] b_datain = '0;
  logic [25:0] b_codeout;
  // CODE_W=10, DATA_W=8
  logic c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_code_err, c_busy;
  logic [7:0] c_datain = '0;
  logic [9:0] c_codeout;

  ifns_serial_encoder dut_a (
    .clock(clock), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .datain(a_datain), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .codeout(a_codeout), .code_err(a_code_err), .busy(a_busy));

  ifns_serial_encoder #(.DATA_W(18), .CODE_W(26), .DPC(2)) dut_b (
    .clock(clock), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .datain(b_datain), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .codeout(b_codeout), .code_err(b_code_err), .busy(b_busy));

  ifns_serial_encoder #(.DATA_W(8), .CODE_W(10), .DPC(1)) dut_c (
    .clock(clock), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .datain(c_datain), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .codeout(c_codeout), .code_err(c_code_err), .busy(c_busy));

  function automatic longint unsigned fibv(input int n);
    longint unsigned f[0:44];
    f[0] = 0; f[1] = 1; f[2] = 1;
    for (int i = 3; i <= 44; i++) f[i] = f[i-1] + f[i-2];
    return f[n];
  endfunction

  // Greedy reference: digit k set when the remainder reaches Fib(k+1), then Fib(k) is removed.
  function automatic longint unsigned model_code(input longint unsigned v, input int cw, output bit err);
    longint unsigned r, code, one;
    one = 1;
    code = 0;
    r = v;
    err = (v >= fibv(cw + 2));
    if (!err)
      for (int k = cw; k >= 1; k--)
        if (r >= fibv(k + 1)) begin
          r = r - fibv(k);
          code = code | (one << (k - 1));
        end
    return code;
  endfunction

  function automatic longint unsigned weighted_sum(input longint unsigned code, input int cw);
    longint unsigned s;
    s = 0;
    for (int k = 1; k <= cw; k++) if (code[k-1]) s = s + fibv(k);
    return s;
  endfunction

  task automatic drive_a(input logic [17:0] d, output int lat, output logic [25:0] code, output logic err);
    @(negedge clock); a_in_valid = 1'b1; a_datain = d; a_out_ready = 1'b1;
    @(posedge clock); #1; a_in_valid = 1'b0; lat = 1;
    while (!a_out_valid && lat < 100) begin @(posedge clock); #1; lat++; end
    code = a_codeout; err = a_code_err;
    @(posedge clock); #1;
  endtask

  task automatic drive_b(input logic [17:0] d, output int lat, output logic [25:0] code, output logic err);
    @(negedge clock); b_in_valid = 1'b1; b_datain = d;
    @(posedge clock); #1; b_in_valid = 1'b0; lat = 1;
    while (!b_out_valid && lat < 100) begin @(posedge clock); #1; lat++; end
    code = b_codeout; err = b_code_err;
    @(posedge clock); #1;
  endtask

  task automatic drive_c(input logic [7:0] d, output int lat, output logic [9:0] code, output logic err);
    @(negedge clock); c_in_valid = 1'b1; c_datain = d;
    @(posedge clock); #1; c_in_valid = 1'b0; lat = 1;
    while (!c_out_valid && lat < 100) begin @(posedge clock); #1; lat++; end
    code = c_codeout; err = c_code_err;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if ({a_codeout, a_code_err, a_out_valid, a_busy} !== 29'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", {a_codeout, a_code_err, a_out_valid, a_busy}); end
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
  endtask

  task automatic test_known();
    logic [17:0] din [4] = '{18'd0, 18'd1, 18'd2, 18'd3};
    logic [25:0] want [4] = '{26'h0000000, 26'h0000001, 26'h0000003, 26'h0000005};
    int lat; logic [25:0] code; logic err; bit merr; longint unsigned exp_code;
    for (int i = 0; i < 4; i++) begin
      drive_a(din[i], lat, code, err);
      n_cmp++; if (code !== want[i]) begin n_bad++; $display("FAIL known_code[%0d]: got %h want %h", din[i], code, want[i]); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL known_err[%0d]: got %b want 0", din[i], err); end
      n_cmp++; if (lat !== 27) begin n_bad++; $display("FAIL known_latency[%0d]: got %0d want 27", din[i], lat); end
    end
    drive_a(18'h3FFFF, lat, code, err);
    exp_code = model_code(64'h3FFFF, 26, merr);
    n_cmp++; if (code !== 26'(exp_code)) begin n_bad++; $display("FAIL max_code: got %h want %h", code, 26'(exp_code)); end
    n_cmp++; if (weighted_sum(longint'(code), 26) !== 64'd262143) begin
      n_bad++; $display("FAIL max_weighted_sum: got %0d want 262143", weighted_sum(longint'(code), 26)); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL max_err: got %b want 0", err); end
  endtask

  task automatic test_random();
    int lat; logic [25:0] code; logic err; bit merr; logic [17:0] d; longint unsigned exp_code;
    for (int i = 0; i < 40; i++) begin
      d = 18'($urandom_range(0, 262143));
      drive_a(d, lat, code, err);
      exp_code = model_code(longint'(d), 26, merr);
      n_cmp++; if (code !== 26'(exp_code) || err !== merr) begin
        n_bad++; $display("FAIL random_code[%0d]: got %h/%b want %h/%b", d, code, err, 26'(exp_code), merr); end
      n_cmp++; if (lat !== 27) begin n_bad++; $display("FAIL random_latency[%0d]: got %0d want 27", d, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] w1, w2, wi; logic [25:0] held; int lat; bit merr;
    w1 = 18'($urandom_range(1000, 262143)); w2 = 18'($urandom_range(1000, 262143)); wi = ~w1;
    @(negedge clock); a_in_valid = 1'b1; a_datain = w1; a_out_ready = 1'b0;
    @(posedge clock); #1; a_datain = wi; lat = 1;
    n_cmp++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
      n_bad++; $display("FAIL conv_ignore_in: got busy=%b in_ready=%b want 1/0", a_busy, a_in_ready); end
    while (!a_out_valid && lat < 100) begin @(posedge clock); #1; lat++; end
    n_cmp++; if (lat !== 27) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 27", lat); end
    held = a_codeout;
    n_cmp++; if (held !== 26'(model_code(longint'(w1), 26, merr))) begin
      n_bad++; $display("FAIL b2b_first_code: got %h want %h", held, 26'(model_code(longint'(w1), 26, merr))); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      n_cmp++; if (a_codeout !== held || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got %h/%b/%b want %h/1/0", i, a_codeout, a_out_valid, a_in_ready, held); end
    end
    @(negedge clock); a_datain = w2; a_out_ready = 1'b1; #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b want 1", a_in_ready); end
    @(posedge clock); #1; a_in_valid = 1'b0; lat = 1;
    n_cmp++; if (a_busy !== 1'b1 || a_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL same_cycle_accept: got busy=%b out_valid=%b want 1/0", a_busy, a_out_valid); end
    while (!a_out_valid && lat < 100) begin @(posedge clock); #1; lat++; end
    n_cmp++; if (lat !== 27 || a_codeout !== 26'(model_code(longint'(w2), 26, merr))) begin
      n_bad++; $display("FAIL b2b_second: got lat=%0d code=%h want 27/%h", lat, a_codeout, 26'(model_code(longint'(w2), 26, merr))); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_conv();
    bit seen;
    @(negedge clock); a_in_valid = 1'b1; a_datain = 18'd12345; a_out_ready = 1'b1;
    @(posedge clock); #1; a_in_valid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock); rst_n = 1'b0; #1;
    n_cmp++; if ({a_codeout, a_code_err, a_out_valid, a_busy} !== 29'd0) begin
      n_bad++; $display("FAIL abort_outputs: got %h want 0", {a_codeout, a_code_err, a_out_valid, a_busy}); end
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready: got %b want 1", a_in_ready); end
    seen = 1'b0;
    repeat (40) begin @(posedge clock); #1; if (a_out_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_result: got out_valid seen=%b want 0", seen); end
  endtask

  task automatic test_dpc2();
    int lat; logic [25:0] code; logic err; bit merr; logic [17:0] d; longint unsigned exp_code;
    for (int i = 0; i < 1000; i++) begin
      d = 18'($urandom_range(0, 262143));
      drive_b(d, lat, code, err);
      exp_code = model_code(longint'(d), 26, merr);
      n_cmp++; if (code !== 26'(exp_code) || err !== merr) begin
        n_bad++; $display("FAIL dpc2_code[%0d]: got %h/%b want %h/%b", d, code, err, 26'(exp_code), merr); end
      n_cmp++; if (lat !== 14) begin n_bad++; $display("FAIL dpc2_latency[%0d]: got %0d want 14", d, lat); end
    end
  endtask

  task automatic test_small_code();
    int lat; logic [9:0] code; logic err; bit merr; logic [7:0] d; longint unsigned exp_code;
    drive_c(8'd144, lat, code, err);
    n_cmp++; if (code !== 10'd0 || err !== 1'b1) begin
      n_bad++; $display("FAIL range_144: got %h/%b want 000/1", code, err); end
    n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL range_latency: got %0d want 11", lat); end
    for (int i = 0; i < 20; i++) begin
      d = (i == 0) ? 8'd143 : 8'($urandom_range(0, 255));
      drive_c(d, lat, code, err);
      exp_code = model_code(longint'(d), 10, merr);
      n_cmp++; if (code !== 10'(exp_code) || err !== merr || lat !== 11) begin
        n_bad++; $display("FAIL small_code[%0d]: got %h/%b/%0d want %h/%b/11", d, code, err, lat, 10'(exp_code), merr); end
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_random();
    test_back_to_back();
    test_reset_mid_conv();
    test_dpc2();
    test_small_code();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
